// File: rtl/pll_seq_pkg.sv
// Shared types and default codes for the video rPLL sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        LOCKED,
        UPDATE,
        FAULT
    } pll_state_t;

    localparam logic [3:0] PSDA_DEFAULT   = 4'b0000;
    localparam logic [3:0] DUTYDA_DEFAULT = 4'b1000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_seq_ctrl_sync_2ff.sv
// Two-flop synchronizer for the raw rPLL LOCK signal; clears to 0 on rst_n.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_seq_ctrl.sv
// rPLL reset sequencer, lock qualifier with retry/fault, and dynamic PSDA/DUTYDA updates.
// Dynamic configuration is built only when PLL_SEQ_DYN_CFG_EN is defined.
module pll_seq_ctrl
    import pll_seq_pkg::*;
#(
    parameter int         RST_CYCLES    = 64,
    parameter int         LOCK_STABLE   = 256,
    parameter int         LOCK_TIMEOUT  = 65535,
    parameter int         MAX_RETRY     = 3,
    parameter int         SETTLE_CYCLES = 32,
    parameter logic [3:0] PSDA_INIT     = PSDA_DEFAULT,
    parameter logic [3:0] DUTYDA_INIT   = DUTYDA_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       cfg_valid,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic       cfg_ready,
    output logic       pll_reset,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    output logic       pll_ready,
    output logic       fault,
    output logic [1:0] retry_cnt
);

    // One counter serves both timed waits (reset hold and post-update settle).
    localparam int PHASE_MAX = max2(RST_CYCLES, SETTLE_CYCLES);
    localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
    localparam int STAB_W    = $clog2(LOCK_STABLE + 1);
    localparam int TO_W      = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [PHASE_W-1:0] RST_LAST    = PHASE_W'(RST_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_DONE   = STAB_W'(LOCK_STABLE);
    localparam logic [TO_W-1:0]    TO_LAST     = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [1:0]         RETRY_LIMIT = 2'(MAX_RETRY);

    logic lock_s;

    pll_state_t         state_reg, state_next;
    logic [PHASE_W-1:0] phase_cnt_reg, phase_cnt_next;
    logic [STAB_W-1:0]  stab_cnt_reg, stab_cnt_next;
    logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
    logic               pll_reset_reg, pll_reset_next;
    logic               pll_ready_reg, pll_ready_next;
    logic               fault_reg, fault_next;
    logic [1:0]         retry_cnt_reg, retry_cnt_next;

`ifdef PLL_SEQ_DYN_CFG_EN
    localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);

    logic [3:0] psda_reg, psda_next;
    logic [3:0] dutyda_reg, dutyda_next;
`endif

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RESET_HOLD;
            phase_cnt_reg <= '0;
            stab_cnt_reg  <= '0;
            to_cnt_reg    <= '0;
            pll_reset_reg <= 1'b1;
            pll_ready_reg <= 1'b0;
            fault_reg     <= 1'b0;
            retry_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            phase_cnt_reg <= phase_cnt_next;
            stab_cnt_reg  <= stab_cnt_next;
            to_cnt_reg    <= to_cnt_next;
            pll_reset_reg <= pll_reset_next;
            pll_ready_reg <= pll_ready_next;
            fault_reg     <= fault_next;
            retry_cnt_reg <= retry_cnt_next;
        end
    end

`ifdef PLL_SEQ_DYN_CFG_EN
    // Codes survive PLL resets and retries; only rst_n restores them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psda_reg   <= PSDA_INIT;
            dutyda_reg <= DUTYDA_INIT;
        end else begin
            psda_reg   <= psda_next;
            dutyda_reg <= dutyda_next;
        end
    end
`endif

    always_comb begin
        state_next     = state_reg;
        phase_cnt_next = phase_cnt_reg;
        stab_cnt_next  = stab_cnt_reg;
        to_cnt_next    = to_cnt_reg;
        pll_reset_next = pll_reset_reg;
        pll_ready_next = pll_ready_reg;
        fault_next     = fault_reg;
        retry_cnt_next = retry_cnt_reg;
`ifdef PLL_SEQ_DYN_CFG_EN
        psda_next      = psda_reg;
        dutyda_next    = dutyda_reg;
`endif

        case (state_reg)
            RESET_HOLD: begin
                if (phase_cnt_reg == RST_LAST) begin
                    state_next     = WAIT_LOCK;
                    phase_cnt_next = '0;
                    stab_cnt_next  = '0;
                    to_cnt_next    = '0;
                    pll_reset_next = 1'b0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + 1'b1;
                end
            end

            WAIT_LOCK: begin
                // Stability completion is tested first so it wins over a coincident timeout.
                if (stab_cnt_reg == STAB_DONE) begin
                    state_next     = LOCKED;
                    pll_ready_next = 1'b1;
                    retry_cnt_next = '0;
                end else if (to_cnt_reg == TO_LAST) begin
                    pll_reset_next = 1'b1;
                    phase_cnt_next = '0;
                    if (retry_cnt_reg == RETRY_LIMIT) begin
                        state_next = FAULT;
                        fault_next = 1'b1;
                    end else begin
                        state_next     = RESET_HOLD;
                        retry_cnt_next = retry_cnt_reg + 2'd1;
                    end
                end else begin
                    to_cnt_next   = to_cnt_reg + 1'b1;
                    stab_cnt_next = lock_s ? stab_cnt_reg + 1'b1 : '0;
                end
            end

            LOCKED: begin
                if (!lock_s) begin
                    state_next     = RESET_HOLD;
                    phase_cnt_next = '0;
                    pll_ready_next = 1'b0;
                    pll_reset_next = 1'b1;
                end
`ifdef PLL_SEQ_DYN_CFG_EN
                else if (cfg_valid) begin
                    state_next     = UPDATE;
                    phase_cnt_next = '0;
                    pll_ready_next = 1'b0;
                    psda_next      = cfg_psda;
                    dutyda_next    = cfg_dutyda;
                end
`endif
            end

`ifdef PLL_SEQ_DYN_CFG_EN
            UPDATE: begin
                if (phase_cnt_reg == SETTLE_LAST) begin
                    phase_cnt_next = '0;
                    if (lock_s) begin
                        state_next     = LOCKED;
                        pll_ready_next = 1'b1;
                    end else begin
                        state_next     = RESET_HOLD;
                        pll_reset_next = 1'b1;
                    end
                end else begin
                    phase_cnt_next = phase_cnt_reg + 1'b1;
                end
            end
`endif

            FAULT: begin
                pll_reset_next = 1'b1;
                fault_next     = 1'b1;
            end

            default: begin
                state_next     = RESET_HOLD;
                phase_cnt_next = '0;
                pll_reset_next = 1'b1;
                pll_ready_next = 1'b0;
            end
        endcase
    end

`ifdef PLL_SEQ_DYN_CFG_EN
    assign cfg_ready  = (state_reg == LOCKED) && lock_s;
    assign pll_psda   = psda_reg;
    assign pll_dutyda = dutyda_reg;
`else
    logic cfg_unused;
    assign cfg_unused = ^{cfg_valid, cfg_psda, cfg_dutyda};
    assign cfg_ready  = 1'b0;
    assign pll_psda   = PSDA_INIT;
    assign pll_dutyda = DUTYDA_INIT;
`endif

    assign pll_reset = pll_reset_reg;
    assign pll_ready = pll_ready_reg;
    assign fault     = fault_reg;
    assign retry_cnt = retry_cnt_reg;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Self-checking bench for pll_seq_ctrl: event timings predicted from the sequencing rules.
module tb_pll_seq_ctrl;

    localparam int         T_RST     = 64;
    localparam int         T_STABLE  = 256;
    localparam int         T_TO      = 1000;
    localparam int         T_SETTLE  = 32;
    localparam int         READY_LAT = 2 + T_STABLE + 1;
    localparam logic [3:0] PSDA_RST  = 4'b0000;
    localparam logic [3:0] DUTY_RST  = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       cfg_valid;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_dutyda;
    logic       cfg_ready;
    logic       pll_reset;
    logic [3:0] pll_psda;
    logic [3:0] pll_dutyda;
    logic       pll_ready;
    logic       fault;
    logic [1:0] retry_cnt;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_psda = PSDA_RST;
    logic [3:0] exp_dutyda = DUTY_RST;

    pll_seq_ctrl #(
        .RST_CYCLES    (T_RST),
        .LOCK_STABLE   (T_STABLE),
        .LOCK_TIMEOUT  (T_TO),
        .MAX_RETRY     (3),
        .SETTLE_CYCLES (T_SETTLE),
        .PSDA_INIT     (PSDA_RST),
        .DUTYDA_INIT   (DUTY_RST)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_lock   (pll_lock),
        .cfg_valid  (cfg_valid),
        .cfg_psda   (cfg_psda),
        .cfg_dutyda (cfg_dutyda),
        .cfg_ready  (cfg_ready),
        .pll_reset  (pll_reset),
        .pll_psda   (pll_psda),
        .pll_dutyda (pll_dutyda),
        .pll_ready  (pll_ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until pll_ready equals val; n = ticks taken, or -1 if the budget ran out.
    task automatic wait_ready(input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (pll_ready === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_reset(input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (pll_reset === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; pll_lock = 1'b0; cfg_valid = 1'b0; cfg_psda = 4'h0; cfg_dutyda = 4'h0;
        repeat (3) tick();
        checks++;
        if ({pll_reset, pll_ready, cfg_ready, fault, retry_cnt, pll_psda, pll_dutyda} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, PSDA_RST, DUTY_RST}) begin
            errors++;
            $display("FAIL reset_values got rst=%b rdy=%b crdy=%b flt=%b retry=%0d psda=%h duty=%h want 1 0 0 0 0 %h %h",
                     pll_reset, pll_ready, cfg_ready, fault, retry_cnt, pll_psda, pll_dutyda, PSDA_RST, DUTY_RST);
        end
        rst_n = 1'b1;
        wait_reset(1'b0, 200, n);
        checks++;
        if (n != T_RST) begin
            errors++;
            $display("FAIL reset_hold_len got=%0d want=%0d", n, T_RST);
        end
        $display("reset: pll_reset held %0d cycles", n);
    endtask

    task automatic test_powerup_lock();
        int n;
        repeat (100) tick();
        pll_lock = 1'b1;
        wait_ready(1'b1, 400, n);
        checks++;
        if (n != READY_LAT) begin
            errors++;
            $display("FAIL powerup_ready_lat got=%0d want=%0d", n, READY_LAT);
        end
        checks++;
        if ({pll_reset, retry_cnt, fault} !== {1'b0, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL powerup_status got rst=%b retry=%0d flt=%b want 0 0 0", pll_reset, retry_cnt, fault);
        end
`ifdef PLL_SEQ_DYN_CFG_EN
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL powerup_cfg_ready got=%b want=1", cfg_ready);
        end
`endif
        $display("powerup: pll_ready after %0d cycles from lock edge", n);
    endtask

`ifdef PLL_SEQ_DYN_CFG_EN
    task automatic test_cfg_update();
        int n;
        int g;
        for (int t = 0; t < 5; t++) begin
            repeat ($urandom_range(1, 5)) tick();
            checks++;
            if ({pll_ready, cfg_ready} !== 2'b11) begin
                errors++;
                $display("FAIL cfg_pre_ready txn=%0d got rdy=%b crdy=%b want 1 1", t, pll_ready, cfg_ready);
            end
            cfg_valid  = 1'b1;
            cfg_psda   = (t == 0) ? 4'h5 : 4'($urandom_range(0, 15));
            cfg_dutyda = (t == 0) ? 4'h6 : 4'($urandom_range(0, 15));
            tick();
            exp_psda   = cfg_psda;
            exp_dutyda = cfg_dutyda;
            cfg_valid  = 1'b0;
            checks++;
            if ({pll_psda, pll_dutyda, pll_ready, cfg_ready} !== {exp_psda, exp_dutyda, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL cfg_apply txn=%0d got psda=%h duty=%h rdy=%b crdy=%b want %h %h 0 0",
                         t, pll_psda, pll_dutyda, pll_ready, cfg_ready, exp_psda, exp_dutyda);
            end
            // Requests raised while settling must be ignored.
            g = $urandom_range(1, 10);
            n = -1;
            for (int k = 1; k <= 60; k++) begin
                cfg_valid = (k <= g);
                cfg_psda  = ~exp_psda;
                cfg_dutyda = ~exp_dutyda;
                tick();
                if (pll_ready === 1'b1) begin
                    n = k;
                    break;
                end
            end
            cfg_valid = 1'b0;
            checks++;
            if (n != T_SETTLE) begin
                errors++;
                $display("FAIL cfg_settle_len txn=%0d got=%0d want=%0d", t, n, T_SETTLE);
            end
            checks++;
            if ({pll_psda, pll_dutyda} !== {exp_psda, exp_dutyda}) begin
                errors++;
                $display("FAIL cfg_settle_ignore txn=%0d got psda=%h duty=%h want %h %h",
                         t, pll_psda, pll_dutyda, exp_psda, exp_dutyda);
            end
            $display("cfg txn %0d: psda=%h dutyda=%h settle=%0d", t, exp_psda, exp_dutyda, n);
        end
    endtask
`else
    task automatic test_static_cfg();
        int bad = 0;
        for (int k = 0; k < 50; k++) begin
            cfg_valid  = 1'($urandom_range(0, 1));
            cfg_psda   = 4'($urandom_range(0, 15));
            cfg_dutyda = 4'($urandom_range(0, 15));
            tick();
            if ({cfg_ready, pll_ready, pll_psda, pll_dutyda} !== {1'b0, 1'b1, PSDA_RST, DUTY_RST}) begin
                bad++;
                if (bad == 1)
                    $display("FAIL static_cfg cycle=%0d got crdy=%b rdy=%b psda=%h duty=%h want 0 1 %h %h",
                             k, cfg_ready, pll_ready, pll_psda, pll_dutyda, PSDA_RST, DUTY_RST);
            end
        end
        cfg_valid = 1'b0;
        checks++;
        if (bad != 0) errors++;
        $display("static cfg: 50 random request cycles, %0d deviations", bad);
    endtask
`endif

    task automatic test_lock_loss();
        int n;
        logic [2:0] rdy_seq;
        pll_lock = 1'b0;
        tick(); rdy_seq[2] = pll_ready;
        tick(); rdy_seq[1] = pll_ready;
`ifdef PLL_SEQ_DYN_CFG_EN
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL loss_cfg_ready got=%b want=0", cfg_ready);
        end
        cfg_valid  = 1'b1;
        cfg_psda   = ~exp_psda;
        cfg_dutyda = ~exp_dutyda;
`endif
        tick(); rdy_seq[0] = pll_ready;
        cfg_valid = 1'b0;
        checks++;
        if (rdy_seq !== 3'b110) begin
            errors++;
            $display("FAIL loss_ready_fall got seq=%b want=110", rdy_seq);
        end
        checks++;
        if ({pll_reset, retry_cnt, pll_psda, pll_dutyda} !== {1'b1, 2'b00, exp_psda, exp_dutyda}) begin
            errors++;
            $display("FAIL loss_state got rst=%b retry=%0d psda=%h duty=%h want 1 0 %h %h",
                     pll_reset, retry_cnt, pll_psda, pll_dutyda, exp_psda, exp_dutyda);
        end
        wait_reset(1'b0, 200, n);
        checks++;
        if (n != T_RST) begin
            errors++;
            $display("FAIL loss_reset_hold got=%0d want=%0d", n, T_RST);
        end
        $display("lock loss: ready seq=%b, reset hold %0d", rdy_seq, n);
    endtask

    task automatic test_glitch();
        int n;
        int d;
        d = $urandom_range(0, 150);
        repeat (d) tick();
        pll_lock = 1'b1;
        repeat (202) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        wait_ready(1'b1, 400, n);
        checks++;
        if (n != READY_LAT) begin
            errors++;
            $display("FAIL glitch_ready_lat got=%0d want=%0d", n, READY_LAT);
        end
        $display("glitch: lock delay=%0d, ready %0d cycles after re-rise", d, n);
    endtask

    task automatic test_lock_vs_timeout();
        int n;
        pll_lock = 1'b0;
        wait_ready(1'b0, 10, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL lvt_ready_fall got=%0d want=3", n);
        end
        wait_reset(1'b0, 200, n);
        // Stability completes on exactly the cycle the timeout would expire.
        repeat (T_TO - READY_LAT) tick();
        pll_lock = 1'b1;
        wait_ready(1'b1, 400, n);
        checks++;
        if (n != READY_LAT) begin
            errors++;
            $display("FAIL lvt_ready_lat got=%0d want=%0d", n, READY_LAT);
        end
        checks++;
        if ({retry_cnt, pll_reset, fault} !== {2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lvt_status got retry=%0d rst=%b flt=%b want 0 0 0", retry_cnt, pll_reset, fault);
        end
        $display("lock vs timeout: ready after %0d, retry=%0d", n, retry_cnt);
    endtask

    task automatic test_timeout_fault();
        int n;
        int bad = 0;
        pll_lock = 1'b0;
        wait_ready(1'b0, 10, n);
        for (int a = 1; a <= 4; a++) begin
            wait_reset(1'b0, 200, n);
            checks++;
            if (n != T_RST) begin
                errors++;
                $display("FAIL retry_hold attempt=%0d got=%0d want=%0d", a, n, T_RST);
            end
            wait_reset(1'b1, T_TO + 100, n);
            checks++;
            if (n != T_TO) begin
                errors++;
                $display("FAIL retry_timeout attempt=%0d got=%0d want=%0d", a, n, T_TO);
            end
            checks++;
            if (a <= 3) begin
                if ({retry_cnt, fault} !== {2'(a), 1'b0}) begin
                    errors++;
                    $display("FAIL retry_count attempt=%0d got retry=%0d flt=%b want %0d 0", a, retry_cnt, fault, a);
                end
            end else begin
                if ({retry_cnt, fault} !== {2'd3, 1'b1}) begin
                    errors++;
                    $display("FAIL fault_entry got retry=%0d flt=%b want 3 1", retry_cnt, fault);
                end
            end
            $display("attempt %0d: wait_lock %0d cycles, retry=%0d fault=%b", a, n, retry_cnt, fault);
        end
        pll_lock = 1'b1;
        for (int k = 0; k < 400; k++) begin
            tick();
            if ({fault, pll_reset, pll_ready} !== 3'b110) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fault_sticky got %0d deviating cycles want 0", bad);
        end
        $display("fault: held %0d cycles with lock present", 400 - bad);
    endtask

    task automatic test_async_reset();
        int n;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pll_reset, pll_ready, cfg_ready, fault, retry_cnt, pll_psda, pll_dutyda} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, PSDA_RST, DUTY_RST}) begin
            errors++;
            $display("FAIL async_reset got rst=%b rdy=%b crdy=%b flt=%b retry=%0d psda=%h duty=%h want 1 0 0 0 0 %h %h",
                     pll_reset, pll_ready, cfg_ready, fault, retry_cnt, pll_psda, pll_dutyda, PSDA_RST, DUTY_RST);
        end
        pll_lock = 1'b0;
        exp_psda = PSDA_RST;
        exp_dutyda = DUTY_RST;
        tick();
        rst_n = 1'b1;
        wait_reset(1'b0, 200, n);
        checks++;
        if (n != T_RST) begin
            errors++;
            $display("FAIL async_rehold got=%0d want=%0d", n, T_RST);
        end
        $display("async reset: outputs restored, reset hold %0d", n);
    endtask

    initial begin
        test_reset();
        test_powerup_lock();
`ifdef PLL_SEQ_DYN_CFG_EN
        test_cfg_update();
`else
        test_static_cfg();
`endif
        test_lock_loss();
        test_glitch();
        test_lock_vs_timeout();
        test_timeout_fault();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_seq_ctrl.md
# pll_seq_ctrl

Sequencer and dynamic-configuration controller for the video rPLL that derives the LCD pixel clock from the 27 MHz board oscillator. It holds the PLL in reset after power-up and then releases it. It qualifies LOCK with a stability window, retries on lock timeout and latches a fault after too many failures. It also applies runtime phase (PSDA) and duty (DUTYDA) updates through a valid/ready handshake. It runs on the PLL reference clock. Its `pll_ready` output gates the release of the pixel-domain reset.

## Interface
- `RST_CYCLES`, 64: cycles `pll_reset` is held high per reset attempt (≥2).
- `LOCK_STABLE`, 256: consecutive synchronized-lock cycles required before ready.
- `LOCK_TIMEOUT`, 65535: cycles allowed in WAIT_LOCK before a retry (~2.4 ms at 27 MHz).
- `MAX_RETRY`, 3: failed attempts tolerated. Attempt number `MAX_RETRY+1` failing → FAULT.
- `SETTLE_CYCLES`, 32: wait after a dynamic update before re-checking lock.
- `PSDA_INIT`, 4'b0000: phase code driven after reset.
- `DUTYDA_INIT`, 4'b1000: duty code driven after reset (50 %).

Ports (direction, width, meaning):
- `clk` in 1: 27 MHz reference clock.
- `rst_n` in 1: asynchronous active-low reset.
- `pll_lock` in 1: raw rPLL LOCK, asynchronous to `clk`.
- `cfg_valid` in 1: update request.
- `cfg_psda` in 4: requested phase code.
- `cfg_dutyda` in 4: requested duty code.
- `cfg_ready` out 1: controller accepts an update this cycle.
- `pll_reset` out 1: to rPLL RESET.
- `pll_psda` out 4: to rPLL PSDA.
- `pll_dutyda` out 4: to rPLL DUTYDA.
- `pll_ready` out 1: PLL locked and stable.
- `fault` out 1: sticky lock failure.
- `retry_cnt` out 2: failed attempts since the last successful lock.

## Operation
- `pll_lock` passes through a 2-flop synchronizer to produce `lock_s`. The FSM uses only `lock_s`.
- States and transitions:
  - RESET_HOLD: `pll_reset`=1. Counts `RST_CYCLES`, then goes to WAIT_LOCK with counters cleared.
  - WAIT_LOCK: `pll_reset`=0. The stability counter increments while `lock_s`=1 and clears whenever `lock_s`=0.
    - Stability counter reaches `LOCK_STABLE` → LOCKED; `retry_cnt` cleared.
    - Otherwise, timeout counter reaches `LOCK_TIMEOUT` → `retry_cnt`+1 and back to RESET_HOLD. If `retry_cnt`==`MAX_RETRY` before the increment, go to FAULT instead.
    - If stability completion and timeout occur in the same cycle, lock wins.
  - LOCKED: `pll_ready`=1 and `cfg_ready`=1.
    - `lock_s`=0 → RESET_HOLD; `retry_cnt` is not incremented.
    - `cfg_valid`&`cfg_ready` → latch `cfg_psda`/`cfg_dutyda` into `pll_psda`/`pll_dutyda` and go to UPDATE.
    - If lock loss and handshake occur in the same cycle, lock loss wins and the request is not accepted (`cfg_ready` is combinationally low when `lock_s`=0).
  - UPDATE: `pll_ready`=0, `cfg_ready`=0. Waits `SETTLE_CYCLES`. Then goes to LOCKED if `lock_s`=1, else to RESET_HOLD.
  - FAULT: `pll_reset`=1, `fault`=1. Terminal until `rst_n` is asserted.
- `pll_psda`/`pll_dutyda` retain their last values across RESET_HOLD and retries. Only `rst_n` restores the INIT codes.
- Counter widths: `$clog2(param+1)`. No counter wraps; each saturates or clears on a state change.

## Timing
- Reset values:
  - state = RESET_HOLD.
  - `pll_reset`=1.
  - `pll_psda`=`PSDA_INIT`, `pll_dutyda`=`DUTYDA_INIT`.
  - `pll_ready`=0, `cfg_ready`=0, `fault`=0, `retry_cnt`=0.
  - Synchronizer flops = 0.
- All outputs are registered except `cfg_ready`, which is `(state==LOCKED) & lock_s`.
- `pll_reset` falls `RST_CYCLES` cycles after `rst_n` deasserts.
- `pll_ready` rises 2 (sync) + `LOCK_STABLE` + 1 cycles after `pll_lock` rises, provided `pll_lock` stays high.
- `pll_ready` falls 3 cycles after `pll_lock` drops (2 sync + 1 register). `pll_reset` rises in the same cycle.
- `pll_psda`/`pll_dutyda` update the cycle after the handshake.
- `rst_n` asserted mid-operation: all outputs take their reset values immediately (asynchronous).

## Configuration
- `PLL_SEQ_DYN_CFG_EN`:
  - Defined: the UPDATE state, the cfg handshake and the PSDA/DUTYDA registers are present.
  - Undefined: `cfg_ready` is tied 0, `cfg_*` inputs are ignored, `pll_psda`/`pll_dutyda` are constants `PSDA_INIT`/`DUTYDA_INIT`, and UPDATE is not generated.

## Structure
- Package `pll_seq_pkg` holds:
  - the FSM state enum (RESET_HOLD, WAIT_LOCK, LOCKED, UPDATE, FAULT);
  - default PSDA/DUTYDA code constants.
- Sub-module `sync_2ff` is the 1-bit two-flop synchronizer for `pll_lock`. It has asynchronous reset to 0.

## Test plan
- Power-up with `pll_lock` rising 100 cycles after `pll_reset` falls → `pll_reset` high for 64 cycles; `pll_ready`=1 exactly 2+256+1 cycles after the lock edge; `retry_cnt`=0.
- `pll_lock` held 0 (with `LOCK_TIMEOUT`=1000 overridden) → 3 retries with `retry_cnt` 1,2,3, then FAULT; `fault`=1 and `pll_reset`=1 until `rst_n` pulses.
- `pll_lock` glitches low for 1 cycle during WAIT_LOCK at stability count 200 → counter restarts; `pll_ready` is delayed accordingly.
- In LOCKED, `cfg_valid` with psda=4'h5, dutyda=4'h6 → `pll_psda`=5 and `pll_dutyda`=6 next cycle; `pll_ready` low for 32 cycles, then high.
- In LOCKED, `pll_lock` drops while `cfg_valid`=1 → request not accepted (codes unchanged); `pll_ready` falls 3 cycles after the drop; RESET_HOLD entered.
- Build without `PLL_SEQ_DYN_CFG_EN` → `cfg_ready` stays 0; `pll_psda`=0 and `pll_dutyda`=4'b1000 under any `cfg_valid` stimulus.
